bcd_counter_display: RTL and testbench

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

---
 rtl/bcd_counter_display.sv | 185 ++++++++++++++++++
 tb/tb_bcd_counter_display.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_display.sv
// -----------------------------------------------------------------------------
// bcd_counter_display
//   Multi-digit BCD up/down counter with edge-detected inc/dec requests, a
//   validated parallel load, limit flags and registered active-low 7-segment
//   outputs, with optional blanking of leading-zero displays.
//
// Parameters
//   DIGITS     number of BCD digits / displays (1..6)
//   MAX        upper count limit as a plain integer (1..10**DIGITS-1)
//   WRAP       1 = wrap around at the limits, 0 = saturate
//   BLANK_LEAD 1 = blank leading-zero displays (digit 0 always shown)
//
// Ports
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   inc, dec  level requests; one step per low-to-high transition
//   load      load strobe, sampled every cycle
//   load_val  BCD load value, digit 0 in [3:0]
//   bcd       current count, digit 0 in [3:0]
//   hex       active-low segments, digit k in [7k+6:7k], bit 0 = seg a
//   at_max    bcd == MAX
//   at_min    bcd == 0
// -----------------------------------------------------------------------------
module bcd_counter_display #(
    parameter int DIGITS     = 2,
    parameter int MAX        = 10**DIGITS - 1,
    parameter int WRAP       = 1,
    parameter int BLANK_LEAD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  at_max,
    output logic                  at_min
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    function automatic logic [BW-1:0] int_to_bcd(input int val);
        logic [BW-1:0] r;
        int            v;
        r = '0;
        v = val;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [BW-1:0] MAX_BCD = int_to_bcd(MAX);

    function automatic logic [BW-1:0] bcd_step_up(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (r[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] bcd_step_down(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (r[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_digits_valid(input logic [BW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic          inc_q, dec_q;
    logic          inc_ev, dec_ev;
    logic          load_ok;
    logic [BW-1:0] bcd_nxt;
    logic [SW-1:0] hex_nxt;
    logic          zero_above;

    // Stage 0: request edge detection and next count
    // inc_q/dec_q track the raw levels even during reset so a level held
    // across reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        inc_q <= inc;
        dec_q <= dec;
    end

    assign inc_ev = inc & ~inc_q;
    assign dec_ev = dec & ~dec_q;

    // Packed BCD compares like an unsigned integer once every digit is valid.
    assign load_ok = all_digits_valid(load_val) && (load_val <= MAX_BCD);

    always_comb begin
        bcd_nxt = bcd;
        if (load) begin
            // A rejected load still swallows any event in the same cycle.
            if (load_ok) bcd_nxt = load_val;
        end else if (inc_ev && !dec_ev) begin
            if (bcd == MAX_BCD) bcd_nxt = (WRAP != 0) ? '0 : MAX_BCD;
            else                bcd_nxt = bcd_step_up(bcd);
        end else if (dec_ev && !inc_ev) begin
            if (bcd == '0) bcd_nxt = (WRAP != 0) ? MAX_BCD : '0;
            else           bcd_nxt = bcd_step_down(bcd);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) bcd <= '0;
        else       bcd <= bcd_nxt;
    end

    assign at_max = (bcd == MAX_BCD);
    assign at_min = (bcd == '0);

    // Stage 1: segment decode of the current count, one cycle behind bcd
    // Walk from the top digit down so zero_above means "this digit and all
    // higher digits are zero".
    always_comb begin
        hex_nxt    = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (bcd[4*k +: 4] == 4'd0);
            if ((BLANK_LEAD != 0) && (k != 0) && zero_above)
                hex_nxt[7*k +: 7] = 7'h7F;
            else
                hex_nxt[7*k +: 7] = seg7(bcd[4*k +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hex <= {DIGITS{7'h40}};
        else       hex <= hex_nxt;
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_display
//   Drives five differently parameterised counters from shared stimulus and
//   compares each against an integer reference model through a scoreboard.
//   u0: 2 digits MAX 99 wrap      u1: 2 digits MAX 99 saturate
//   u2: 2 digits MAX 59 wrap      u3: 3 digits MAX 999 wrap, leading blank
//   u4: 1 digit  MAX 7  wrap
// -----------------------------------------------------------------------------
module tb_bcd_counter_display;

    localparam int N = 5;
    localparam int P_D    [N] = '{2, 2, 2, 3, 1};
    localparam int P_MAX  [N] = '{99, 99, 59, 999, 7};
    localparam int P_WRAP [N] = '{1, 0, 1, 1, 1};
    localparam int P_BL   [N] = '{0, 0, 0, 1, 0};
    localparam logic [6:0] SEG [10] =
        '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_val = '0;

    logic [7:0]  b0, b1, b2;
    logic [11:0] b3;
    logic [3:0]  b4;
    logic [13:0] h0, h1, h2;
    logic [20:0] h3;
    logic [6:0]  h4;
    logic [N-1:0] mx, mn;

    logic [23:0] bq [N];
    logic [41:0] hq [N];

    assign bq[0] = 24'(b0);  assign hq[0] = 42'(h0);
    assign bq[1] = 24'(b1);  assign hq[1] = 42'(h1);
    assign bq[2] = 24'(b2);  assign hq[2] = 42'(h2);
    assign bq[3] = 24'(b3);  assign hq[3] = 42'(h3);
    assign bq[4] = 24'(b4);  assign hq[4] = 42'(h4);

    always #5 clk = ~clk;

    bcd_counter_display #(.DIGITS(2), .MAX(99), .WRAP(1), .BLANK_LEAD(0)) u0 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[7:0]), .bcd(b0), .hex(h0), .at_max(mx[0]), .at_min(mn[0]));
    bcd_counter_display #(.DIGITS(2), .MAX(99), .WRAP(0), .BLANK_LEAD(0)) u1 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[7:0]), .bcd(b1), .hex(h1), .at_max(mx[1]), .at_min(mn[1]));
    bcd_counter_display #(.DIGITS(2), .MAX(59), .WRAP(1), .BLANK_LEAD(0)) u2 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[7:0]), .bcd(b2), .hex(h2), .at_max(mx[2]), .at_min(mn[2]));
    bcd_counter_display #(.DIGITS(3), .MAX(999), .WRAP(1), .BLANK_LEAD(1)) u3 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[11:0]), .bcd(b3), .hex(h3), .at_max(mx[3]), .at_min(mn[3]));
    bcd_counter_display #(.DIGITS(1), .MAX(7), .WRAP(1), .BLANK_LEAD(0)) u4 (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_val(load_val[3:0]), .bcd(b4), .hex(h4), .at_max(mx[4]), .at_min(mn[4]));

    typedef struct {
        int          idx;
        logic [23:0] b;
        logic [41:0] h;
        logic        mx;
        logic        mn;
    } exp_t;

    exp_t sb[$];
    int   cnt [N];
    logic pinc = 1'b0;
    logic pdec = 1'b0;
    int   nchecks = 0;
    int   nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_bcd(input int c);
        logic [23:0] r;
        int          v;
        r = '0;
        v = c;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] ref_hex(input int c, input int d, input int bl);
        logic [41:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int k = 0; k < d; k++) begin
            if (bl != 0 && k > 0 && c < p) r[7*k +: 7] = 7'h7F;
            else                           r[7*k +: 7] = SEG[(c / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // One clock: drive at negedge, predict every instance, compare after posedge.
    task automatic step(input logic r, input logic i, input logic d,
                        input logic l, input logic [23:0] v);
        logic ie, de, ok;
        int   val, nc, dg;
        exp_t e;
        @(negedge clk);
        reset = r; inc = i; dec = d; load = l; load_val = v;
        ie = i & ~pinc;
        de = d & ~pdec;
        for (int j = 0; j < N; j++) begin
            e.idx = j;
            if (r) begin
                e.h = ref_hex(0, P_D[j], 0);
                nc  = 0;
            end else begin
                e.h = ref_hex(cnt[j], P_D[j], P_BL[j]);
                nc  = cnt[j];
                if (l) begin
                    ok  = 1'b1;
                    val = 0;
                    for (int k = P_D[j] - 1; k >= 0; k--) begin
                        dg = int'(v[4*k +: 4]);
                        if (dg > 9) ok = 1'b0;
                        val = val * 10 + dg;
                    end
                    if (val > P_MAX[j]) ok = 1'b0;
                    if (ok) nc = val;
                end else if (ie && !de) begin
                    if (cnt[j] == P_MAX[j]) nc = (P_WRAP[j] != 0) ? 0 : P_MAX[j];
                    else                    nc = cnt[j] + 1;
                end else if (de && !ie) begin
                    if (cnt[j] == 0) nc = (P_WRAP[j] != 0) ? P_MAX[j] : 0;
                    else             nc = cnt[j] - 1;
                end
            end
            cnt[j] = nc;
            e.b  = ref_bcd(nc);
            e.mx = (nc == P_MAX[j]);
            e.mn = (nc == 0);
            sb.push_back(e);
        end
        pinc = i;
        pdec = d;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("u%0d_bcd", e.idx), 64'(bq[e.idx]), 64'(e.b));
            check($sformatf("u%0d_hex", e.idx), 64'(hq[e.idx]), 64'(e.h));
            check($sformatf("u%0d_at_max", e.idx), 64'(mx[e.idx]), 64'(e.mx));
            check($sformatf("u%0d_at_min", e.idx), 64'(mn[e.idx]), 64'(e.mn));
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic pulse_inc();
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic pulse_dec();
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic do_load(input logic [23:0] v);
        step(1'b0, 1'b0, 1'b0, 1'b1, v);
        idle(2);
    endtask

    initial begin
        logic [23:0] rv;
        for (int j = 0; j < N; j++) cnt[j] = 0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        idle(2);

        // twelve increments, then let hex catch up
        for (int n = 0; n < 12; n++) pulse_inc();
        idle(2);

        // load top value and wrap / saturate on increment
        do_load(24'h99);
        pulse_inc();
        idle(1);

        // decrement from zero
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        pulse_dec();
        idle(1);

        // held increment gives one step; simultaneous edges cancel
        for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
        idle(2);

        // illegal loads, and an illegal load swallowing an increment edge
        do_load(24'h1A);
        do_load(24'h75);
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h1A);
        idle(2);
        do_load(24'h3F);

        // level held high across reset release
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        idle(1);

        // leading-zero blanking values
        do_load(24'h007);
        do_load(24'h100);
        do_load(24'h050);

        // reset overriding load and event
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 24'h055);
        idle(2);

        // long decrement and increment sweeps across limits
        for (int n = 0; n < 15; n++) pulse_dec();
        for (int n = 0; n < 25; n++) pulse_inc();
        do_load(24'h58);
        for (int n = 0; n < 3; n++) pulse_inc();

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            rv = '0;
            for (int k = 0; k < 6; k++) rv[4*k +: 4] = 4'($urandom_range(0, 11));
            step(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rv);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
